// File: rtl/branch_resolver.sv
// Branch resolver: architectural NZCV flags, interlock against in-flight flag writers,
// handshake-driven conditional jump resolution and a 2-bit saturating branch-history table.
module branch_resolver #(
    parameter int         PC_W      = 16,
    parameter int         BHT_DEPTH = 16,
    parameter logic [1:0] CTR_INIT  = 2'b01,
    parameter int         PEND_MAX  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flag_we,
    input  logic [3:0]      flag_in,
    input  logic            flag_pend,
    input  logic            flush,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [PC_W-1:0] br_pc,
    input  logic [3:0]      br_cond,
    input  logic            br_is_jmp,
    input  logic            br_pred,
    input  logic [PC_W-1:0] fetch_pc,
    output logic            pred_taken,
    output logic            res_valid,
    output logic            res_taken,
    output logic            res_mispredict,
    output logic [PC_W-1:0] res_pc,
    output logic [3:0]      flags_out,
    output logic            flags_busy
);
    localparam int IDX_W  = $clog2(BHT_DEPTH);
    localparam int PEND_W = $clog2(PEND_MAX + 1);
    localparam logic [PEND_W-1:0] PEND_LIM = PEND_W'(PEND_MAX);

    // Condition encodings shared with the decoder.
    localparam logic [3:0] COND_JMP = 4'h0;
    localparam logic [3:0] COND_JEQ = 4'h1;
    localparam logic [3:0] COND_JNE = 4'h2;
    localparam logic [3:0] COND_JGE = 4'h3;
    localparam logic [3:0] COND_JLT = 4'h4;
    localparam logic [3:0] COND_JGT = 4'h5;
    localparam logic [3:0] COND_JLE = 4'h6;

    typedef enum logic [1:0] {IDLE, WAIT, EVAL} state_t;

    state_t            state_reg, state_next;
    logic [PEND_W-1:0] pend_reg, pend_next;
    logic [3:0]        flags_reg;
    logic [PC_W-1:0]   hold_pc_reg;
    logic [3:0]        hold_cond_reg;
    logic              hold_jmp_reg;
    logic              hold_pred_reg;
    logic              res_valid_reg, res_taken_reg, res_mis_reg;
    logic [PC_W-1:0]   res_pc_reg;
    logic [1:0]        bht_reg  [BHT_DEPTH];
    logic [1:0]        bht_next [BHT_DEPTH];

    logic              accept, eval_fire, cond_true, eval_taken, bht_we;
    logic [IDX_W-1:0]  upd_idx;
    logic [1:0]        ctr_cur, ctr_upd;
    logic              unused_fetch_hi;

    assign unused_fetch_hi = ^fetch_pc[PC_W-1:IDX_W];

    // A simultaneous issue and retire cancel; saturation at both ends is silent.
    always_comb begin
        pend_next = pend_reg;
        if (flag_pend && !flag_we && pend_reg != PEND_LIM)
            pend_next = pend_reg + PEND_W'(1);
        else if (flag_we && !flag_pend && pend_reg != '0)
            pend_next = pend_reg - PEND_W'(1);
    end

    always_comb begin
        accept     = br_valid && (state_reg == IDLE) && !flush;
        eval_fire  = (state_reg == EVAL) && !flush;
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = (pend_next != '0) ? WAIT : EVAL;
            WAIT: if (pend_next == '0) state_next = EVAL;
            EVAL: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_comb begin
        cond_true = 1'b0;
        case (hold_cond_reg)
            COND_JMP: cond_true = 1'b1;
            COND_JEQ: cond_true = flags_reg[2];
            COND_JNE: cond_true = !flags_reg[2];
            COND_JGE: cond_true = (flags_reg[3] == flags_reg[0]);
            COND_JLT: cond_true = (flags_reg[3] != flags_reg[0]);
            COND_JGT: cond_true = !flags_reg[2] && (flags_reg[3] == flags_reg[0]);
            COND_JLE: cond_true = flags_reg[2] || (flags_reg[3] != flags_reg[0]);
            default:  cond_true = 1'b0;
        endcase
    end

    assign eval_taken = cond_true && hold_jmp_reg;
    assign bht_we     = eval_fire && hold_jmp_reg;
    assign upd_idx    = hold_pc_reg[IDX_W-1:0];
    assign ctr_cur    = bht_reg[upd_idx];

    always_comb begin
        ctr_upd = ctr_cur;
        if (eval_taken) begin
            if (ctr_cur != 2'b11) ctr_upd = ctr_cur + 2'b01;
        end else begin
            if (ctr_cur != 2'b00) ctr_upd = ctr_cur - 2'b01;
        end
    end

    generate
        for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
            assign bht_next[gi] = (bht_we && upd_idx == IDX_W'(gi)) ? ctr_upd : bht_reg[gi];
        end
    endgenerate

    // Lookup reads the current array, so a same-cycle update is not visible yet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht_reg[i] <= CTR_INIT;
        end else begin
            bht_reg <= bht_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            pend_reg      <= '0;
            flags_reg     <= 4'b0000;
            hold_pc_reg   <= '0;
            hold_cond_reg <= 4'h0;
            hold_jmp_reg  <= 1'b0;
            hold_pred_reg <= 1'b0;
            res_valid_reg <= 1'b0;
            res_taken_reg <= 1'b0;
            res_mis_reg   <= 1'b0;
            res_pc_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            pend_reg      <= pend_next;
            res_valid_reg <= eval_fire;
            if (flag_we) flags_reg <= flag_in;
            if (accept) begin
                hold_pc_reg   <= br_pc;
                hold_cond_reg <= br_cond;
                hold_jmp_reg  <= br_is_jmp;
                hold_pred_reg <= br_pred;
            end
            if (eval_fire) begin
                res_taken_reg <= eval_taken;
                res_mis_reg   <= (eval_taken != hold_pred_reg);
                res_pc_reg    <= hold_pc_reg;
            end
        end
    end

    assign br_ready       = (state_reg == IDLE);
    assign pred_taken     = bht_reg[fetch_pc[IDX_W-1:0]][1];
    assign res_valid      = res_valid_reg;
    assign res_taken      = res_taken_reg;
    assign res_mispredict = res_mis_reg;
    assign res_pc         = res_pc_reg;
    assign flags_out      = flags_reg;
    assign flags_busy     = (pend_reg != '0);
endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: expected results are queued at issue time
// and popped whenever res_valid is seen.
module tb_branch_resolver;
    localparam logic [3:0] JMP = 4'h0, JEQ = 4'h1, JNE = 4'h2, JGE = 4'h3,
                           JLT = 4'h4, JGT = 4'h5, JLE = 4'h6, CNONE = 4'hF;

    localparam logic [3:0] TT_FLAGS [8] = '{4'b0100, 4'b1011, 4'b1011, 4'b1100,
                                           4'b0010, 4'b0101, 4'b0000, 4'b1011};
    localparam logic [3:0] TT_COND  [8] = '{JEQ, JEQ, JGT, JGE, JLE, JLT, CNONE, JNE};
    localparam logic       TT_EXP   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flag_we = 1'b0;
    logic [3:0]  flag_in = 4'h0;
    logic        flag_pend = 1'b0;
    logic        flush = 1'b0;
    logic        br_valid = 1'b0;
    logic        br_ready;
    logic [15:0] br_pc = 16'h0;
    logic [3:0]  br_cond = 4'h0;
    logic        br_is_jmp = 1'b0;
    logic        br_pred = 1'b0;
    logic [15:0] fetch_pc = 16'h0;
    logic        pred_taken, res_valid, res_taken, res_mispredict, flags_busy;
    logic [15:0] res_pc;
    logic [3:0]  flags_out;

    typedef struct packed {
        logic        taken;
        logic        mis;
        logic [15:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_res = 0;
    logic [3:0] exp_flags = 4'h0;

    always #5 clk = ~clk;

    branch_resolver dut (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_in(flag_in),
        .flag_pend(flag_pend), .flush(flush), .br_valid(br_valid), .br_ready(br_ready),
        .br_pc(br_pc), .br_cond(br_cond), .br_is_jmp(br_is_jmp), .br_pred(br_pred),
        .fetch_pc(fetch_pc), .pred_taken(pred_taken), .res_valid(res_valid),
        .res_taken(res_taken), .res_mispredict(res_mispredict), .res_pc(res_pc),
        .flags_out(flags_out), .flags_busy(flags_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (res_valid === 1'b1) begin
            n_res++;
            if (sb.size() == 0) begin
                chk("res_unexpected", res_valid, 0);
            end else begin
                e = sb.pop_front();
                $display("result pc=%h taken=%0b mispredict=%0b (exp %0b/%0b)",
                         res_pc, res_taken, res_mispredict, e.taken, e.mis);
                chk("res_taken", res_taken, e.taken);
                chk("res_mispredict", res_mispredict, e.mis);
                chk("res_pc", res_pc, e.pc);
            end
        end
    endtask

    task automatic issue(input logic [15:0] pc, input logic [3:0] cond, input logic jmp,
                         input logic pred, input logic push, input logic exp_taken);
        br_valid = 1'b1; br_pc = pc; br_cond = cond; br_is_jmp = jmp; br_pred = pred;
        chk("br_ready_at_issue", br_ready, 1);
        if (push) sb.push_back('{exp_taken, exp_taken ^ pred, pc});
        $display("issue pc=%h cond=%h jmp=%0b pred=%0b flags=%b", pc, cond, jmp, pred, flags_out);
        step();
        br_valid = 1'b0;
    endtask

    task automatic run_branch(input logic [15:0] pc, input logic [3:0] cond, input logic jmp,
                              input logic pred, input logic exp_taken);
        int n0;
        n0 = n_res;
        issue(pc, cond, jmp, pred, 1'b1, exp_taken);
        chk("no_res_in_eval", n_res, n0);
        chk("ready_low_in_eval", br_ready, 0);
        step();
        chk("latency_1", n_res, n0 + 1);
    endtask

    task automatic set_flags(input logic [3:0] f);
        flag_we = 1'b1; flag_in = f;
        step();
        flag_we = 1'b0;
        exp_flags = f;
        chk("flags_out", flags_out, exp_flags);
    endtask

    task automatic pend_pulse();
        flag_pend = 1'b1;
        step();
        flag_pend = 1'b0;
    endtask

    initial begin
        int n0;
        // Reset values
        #12;
        chk("rst_br_ready", br_ready, 1);
        chk("rst_flags_busy", flags_busy, 0);
        chk("rst_flags_out", flags_out, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_pc", res_pc, 0);
        chk("rst_pred_taken", pred_taken, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Condition truth table
        for (int i = 0; i < 8; i++) begin
            set_flags(TT_FLAGS[i]);
            run_branch(16'h0108 + 16'(i), TT_COND[i], 1'b1, 1'(i % 2), TT_EXP[i]);
        end
        set_flags(4'b1111);
        for (int c = 0; c < 8; c++) begin
            logic [3:0] cc;
            cc = (c == 7) ? CNONE : 4'(c);
            run_branch(16'h0208 + 16'(c), cc, 1'b0, 1'b1, 1'b0);
        end

        // Interlock on two pending writers
        pend_pulse();
        pend_pulse();
        chk("busy_after_pend", flags_busy, 1);
        n0 = n_res;
        issue(16'h0030, JEQ, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        chk("wait_ready_low", br_ready, 0);
        set_flags(4'b0000);
        chk("wait_no_res", n_res, n0);
        set_flags(4'b0100);
        chk("busy_cleared", flags_busy, 0);
        chk("no_res_at_retire", n_res, n0);
        step();
        chk("res_after_retire", n_res, n0 + 1);

        // Counter training and aliasing
        fetch_pc = 16'h0005;
        #1;
        chk("pred_init", pred_taken, 0);
        issue(16'h0005, JMP, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("pred_read_before_write", pred_taken, 0);
        step();
        chk("pred_after_first", pred_taken, 1);
        run_branch(16'h0005, JMP, 1'b1, 1'b0, 1'b1);
        run_branch(16'h0005, JMP, 1'b1, 1'b0, 1'b1);
        chk("pred_saturated", pred_taken, 1);
        run_branch(16'h0005, CNONE, 1'b1, 1'b1, 1'b0);
        chk("pred_after_nt", pred_taken, 1);
        run_branch(16'h0015, CNONE, 1'b1, 1'b1, 1'b0);
        chk("pred_alias", pred_taken, 0);

        // Pending counter boundaries
        set_flags(4'b1010);
        chk("busy_dec_at_zero", flags_busy, 0);
        pend_pulse();
        chk("busy_one", flags_busy, 1);
        flag_pend = 1'b1; flag_we = 1'b1; flag_in = 4'b0001;
        step();
        flag_pend = 1'b0; flag_we = 1'b0; exp_flags = 4'b0001;
        chk("simul_flags", flags_out, exp_flags);
        chk("simul_busy", flags_busy, 1);
        set_flags(4'b0001);
        chk("simul_count_was_1", flags_busy, 0);
        for (int i = 0; i < 5; i++) pend_pulse();
        set_flags(4'b0001);
        set_flags(4'b0001);
        chk("sat_busy_at_1", flags_busy, 1);
        set_flags(4'b0001);
        chk("sat_busy_at_0", flags_busy, 0);

        // Flush in WAIT and flush with a request offered
        pend_pulse();
        n0 = n_res;
        issue(16'h0005, JMP, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("flush_pre_ready", br_ready, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_ready", br_ready, 1);
        chk("flush_busy_kept", flags_busy, 1);
        set_flags(4'b0001);
        step();
        step();
        chk("flush_no_res", n_res, n0);
        chk("flush_ctr_kept", pred_taken, 0);
        flush = 1'b1; br_valid = 1'b1; br_pc = 16'h0005; br_cond = JMP; br_is_jmp = 1'b1;
        step();
        flush = 1'b0; br_valid = 1'b0;
        step();
        step();
        chk("flush_no_accept", n_res, n0);
        chk("flush_no_accept_ctr", pred_taken, 0);

        // Reset in EVAL
        fetch_pc = 16'h0007;
        run_branch(16'h0007, JMP, 1'b1, 1'b0, 1'b1);
        chk("pre_rst_pred", pred_taken, 1);
        issue(16'h0009, JMP, 1'b1, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_eval_ready", br_ready, 1);
        chk("rst_eval_flags", flags_out, 0);
        chk("rst_eval_busy", flags_busy, 0);
        chk("rst_eval_taken", res_taken, 0);
        chk("rst_eval_mis", res_mispredict, 0);
        chk("rst_eval_pc", res_pc, 0);
        chk("rst_eval_pred", pred_taken, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n0 = n_res;
        step();
        step();
        chk("rst_discard", n_res, n0);
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/branch_resolver.md
# branch_resolver

Sequential, parametrised successor to the combinational condition checker. Holds the architectural NZCV flags and interlocks branches against in-flight flag writers. Resolves conditional jumps through a valid/ready handshake and trains a table of 2-bit saturating branch-history counters that also serves fetch-stage predictions. Sits between decode/issue (requests), the ALU writeback (flag updates) and fetch (prediction, mispredict redirect).

## Interface
- PC_W, 16: width of br_pc / fetch_pc / res_pc.
- BHT_DEPTH, 16: number of 2-bit counters; power of two, ≥2; IDX_W = log2(BHT_DEPTH).
- CTR_INIT, 2'b01: counter reset value (weakly not-taken).
- PEND_MAX, 3: saturation limit of the pending-flag-writer counter.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flag_we  in  1  write flag_in into architectural flags; also retires one pending writer.
- flag_in  in  4  {N,Z,C,V}.
- flag_pend  in  1  a flag-setting op has issued (pending count +1).
- flush  in  1  abort any held request.
- br_valid  in  1  request valid.
- br_ready  out  1  request accepted when br_valid && br_ready.
- br_pc  in  PC_W  branch PC.
- br_cond  in  4  `COND_*` code from defines.v.
- br_is_jmp  in  1  request is a jump op.
- br_pred  in  1  prediction fetch used for this branch.
- fetch_pc  in  PC_W  prediction lookup address.
- pred_taken  out  1  combinational: MSB of counter at fetch_pc[IDX_W-1:0].
- res_valid  out  1  one-cycle result strobe.
- res_taken  out  1  resolved direction.
- res_mispredict  out  1  res_taken != held br_pred.
- res_pc  out  PC_W  held br_pc.
- flags_out  out  4  architectural flags.
- flags_busy  out  1  pending count != 0.

## Operation
- Condition evaluation on flags {N,Z,C,V}:
  - JMP: 1.
  - JEQ: Z.
  - JNE: !Z.
  - JGE: N==V.
  - JLT: N!=V.
  - JGT: !Z && N==V.
  - JLE: Z || N!=V.
  - Any other code: 0.
  - Taken = eval && br_is_jmp.
- Pending counter:
  - +1 on flag_pend; −1 on flag_we.
  - Both in the same cycle: unchanged.
  - Increment at PEND_MAX: ignored (holds).
  - Decrement at 0: ignored; flag_we still writes the flags.
- FSM states: IDLE, WAIT, EVAL.
  - br_ready = (state == IDLE).
  - IDLE: on accept, register pc/cond/is_jmp/pred. Next state is WAIT if the next-cycle pending count != 0, else EVAL.
  - WAIT: go to EVAL in the cycle after the pending count reaches 0.
  - EVAL: evaluate the registered flag value, assert res_valid, update the BHT, return to IDLE.
- BHT update: only in EVAL with is_jmp=1, at index res_pc[IDX_W-1:0].
  - Taken: counter +1, saturating at 3.
  - Not taken: counter −1, saturating at 0.
- Same-cycle lookup and update at the same index: pred_taken returns the pre-update value (read-before-write).
- flush:
  - Forces IDLE; suppresses res_valid and the BHT update.
  - A request offered during flush is not accepted.
  - Flags and pending count are unaffected.
- Reset:
  - state = IDLE.
  - flags_out = 0000, pending count = 0, all counters = CTR_INIT.
  - res_valid/res_taken/res_mispredict = 0, res_pc = 0.
  - br_ready = 1, flags_busy = 0.
  - Reset mid-request discards the request with no result.

## Timing
- No pending writers: accept at edge N; res_valid high for the cycle after edge N+1 (latency 1).
- Flag write at the same edge as accept, with pending count 1→0: goes straight to EVAL and uses the new flags.
- Pending: EVAL is entered on the edge after the retiring flag_we, so EVAL sees the written flags.
- Back-to-back throughput: one branch every 2 cycles, since br_ready is low during EVAL.
- res_* outputs are registered and hold their value between strobes; only res_valid pulses.

## Test plan
- Flag truth table:
  - JEQ with flags 0100 → taken.
  - JEQ with 1011 → not taken.
  - JGT with 1011 → taken.
  - JGE with 1100 → not taken.
  - JLE with 0010 → not taken.
  - JLT with 0101 → taken.
  - cond 4'hF → not taken.
  - is_jmp=0 → not taken for every cond.
  - Each case: res_valid exactly 1 cycle after accept.
- Interlock:
  - flag_pend twice; issue JEQ → br_ready low, no res_valid.
  - flag_we 0000, then flag_we 0100 → res_valid one cycle after the second write, res_taken=1.
- Counter training at pc 0x0005:
  - Counter starts at 01.
  - Three taken JMPs with br_pred=0 → mispredicts 1,1,1; pred_taken(0x0005) becomes 1 after the first.
  - Counter saturates at 11; one not-taken → 10, pred stays 1.
- Aliasing: pc 0x0015 with BHT_DEPTH=16 shares the counter of pc 0x0005.
- Simultaneous flag_pend + flag_we at count 1 → count stays 1, flags updated.
- flush in WAIT → no res_valid, counter unchanged, br_ready high next cycle.
- rst_n low in EVAL → every output back to its reset value immediately.
